// File: rtl/cec_receiver.sv
// cec_receiver
// Bit-level HDMI-CEC receiver for the 27 MHz video clock domain. Synchronises
// the open-drain CEC line, measures low widths and edge-to-edge periods,
// recognises start bits, decodes 10-bit blocks (8 data bits, EOM, ACK) and
// pulls the ACK slot low for blocks addressed to our own logical address.
//
// Ports
//   clk          system clock, 27 MHz
//   rst_n        asynchronous reset, active-low
//   logical_addr own logical address; 4'hF disables directed ACK
//   cec_in       raw CEC line level (asynchronous)
//   cec_send     1 while this block drives cec_out onto the line
//   cec_out      level driven while cec_send=1 (0 when driving)
//   rx_data      last received data byte (MSB first on the wire)
//   rx_eom       EOM bit of the last block
//   rx_header    last block was the first block after a start bit
//   rx_acked     ACK outcome of the last block
//   rx_valid     one-cycle pulse, rx_* fields update on the same cycle
//   frame_error  one-cycle pulse on a timing violation, frame abandoned
module cec_receiver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] logical_addr,
  input  logic       cec_in,
  output logic       cec_send,
  output logic       cec_out,
  output logic [7:0] rx_data,
  output logic       rx_eom,
  output logic       rx_header,
  output logic       rx_acked,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int unsigned CLK_HZ       = 27_000_000;
  localparam int unsigned TICKS_PER_US = CLK_HZ / 1_000_000;

  localparam logic [16:0] CNT_MAX       = 17'h1FFFF;
  localparam logic [16:0] START_MIN     = 17'(3500 * TICKS_PER_US);
  localparam logic [16:0] START_MAX     = 17'(3900 * TICKS_PER_US);
  localparam logic [16:0] ONE_MIN       = 17'(400 * TICKS_PER_US);
  localparam logic [16:0] ONE_MAX       = 17'(800 * TICKS_PER_US);
  localparam logic [16:0] ZERO_MIN      = 17'(1300 * TICKS_PER_US);
  localparam logic [16:0] ZERO_MAX      = 17'(1700 * TICKS_PER_US);
  localparam logic [16:0] START_PER_MIN = 17'(4300 * TICKS_PER_US);
  localparam logic [16:0] START_PER_MAX = 17'(4700 * TICKS_PER_US);
  localparam logic [16:0] BIT_PER_MIN   = 17'(2050 * TICKS_PER_US);
  localparam logic [16:0] HIGH_TIMEOUT  = 17'(2750 * TICKS_PER_US);
  localparam logic [16:0] ACK_CYCLES    = 17'(1500 * TICKS_PER_US);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    GAP
  } state_t;

  state_t      state, state_next;

  logic        sync1, sync2, level_q;
  logic        fall, rise;
  logic [16:0] low_t, per_t, high_t, ack_t;

  logic [8:0]  sr;
  logic [9:0]  sr_next;
  logic [3:0]  bit_cnt;
  logic        hdr;
  logic        frame_active;
  logic [3:0]  dest;
  logic [3:0]  dest_now;

  logic        is_start, is_one, is_zero;
  logic        after_start, period_ok, ack_hit;
  logic        do_start, do_bit, do_error, do_ack;

  // Two-flop synchroniser plus the level register used for edge detection.
  // Reset to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync1   <= cec_in;
      sync2   <= sync1;
      level_q <= sync2;
    end
  end

  assign fall = level_q & ~sync2;
  assign rise = ~level_q & sync2;

  // Counters restart at 1 on their edge so that, when the closing edge is
  // seen, they hold the number of cycles the line spent in that phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_t  <= '0;
      per_t  <= '0;
      high_t <= '0;
    end else begin
      if (fall)                low_t <= 17'd1;
      else if (low_t != CNT_MAX) low_t <= low_t + 17'd1;

      if (fall)                per_t <= 17'd1;
      else if (per_t != CNT_MAX) per_t <= per_t + 17'd1;

      if (rise)                 high_t <= 17'd1;
      else if (high_t != CNT_MAX) high_t <= high_t + 17'd1;
    end
  end

  assign is_start = (low_t >= START_MIN) && (low_t <= START_MAX);
  assign is_one   = (low_t >= ONE_MIN)   && (low_t <= ONE_MAX);
  assign is_zero  = (low_t >= ZERO_MIN)  && (low_t <= ZERO_MAX);

  assign sr_next  = {sr, is_one};

  // During the header block the destination is not latched yet; take it from
  // the low nibble of the data bits already shifted in (sr[8:1] is the byte
  // once 9 bits are in).
  assign dest_now = hdr ? sr[4:1] : dest;

  assign after_start = hdr && (bit_cnt == 4'd0);
  assign period_ok   = after_start ? ((per_t >= START_PER_MIN) && (per_t <= START_PER_MAX))
                                   : (per_t >= BIT_PER_MIN);
  assign ack_hit     = (bit_cnt == 4'd9) && (dest_now != 4'hF) &&
                       (dest_now == logical_addr) && (logical_addr != 4'hF);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and action strobes. A start bit is refused while we are still
  // pulling the line low ourselves.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_bit     = 1'b0;
    do_error   = 1'b0;
    do_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_next = LOW;
      end
      LOW: begin
        if (rise) begin
          if (is_start && !cec_send) begin
            do_start   = 1'b1;
            state_next = GAP;
          end else if ((is_one || is_zero) && frame_active) begin
            do_bit     = 1'b1;
            state_next = GAP;
          end else begin
            do_error   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (fall) begin
          if (!period_ok) begin
            do_error   = 1'b1;
            state_next = IDLE;
          end else begin
            do_ack     = ack_hit;
            state_next = LOW;
          end
        end else if (high_t >= HIGH_TIMEOUT) begin
          // A quiet line is a clean end only right after a completed EOM block.
          do_error   = !((bit_cnt == 4'd0) && !hdr && rx_eom);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Block assembly and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      bit_cnt      <= '0;
      hdr          <= 1'b0;
      frame_active <= 1'b0;
      dest         <= '0;
      rx_data      <= '0;
      rx_eom       <= 1'b0;
      rx_header    <= 1'b0;
      rx_acked     <= 1'b0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= do_error;
      if (do_start) begin
        bit_cnt      <= '0;
        hdr          <= 1'b1;
        frame_active <= 1'b1;
      end else if (do_bit) begin
        sr <= sr_next[8:0];
        if (bit_cnt == 4'd9) begin
          rx_data   <= sr_next[9:2];
          rx_eom    <= sr_next[1];
          rx_header <= hdr;
          // Broadcast: a 1 on the ACK slot means nobody rejected it.
          rx_acked  <= (dest_now == 4'hF) ? sr_next[0] : ~sr_next[0];
          rx_valid  <= 1'b1;
          if (hdr) dest <= sr_next[5:2];
          hdr     <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
      if (state_next == IDLE) frame_active <= 1'b0;
    end
  end

  // ACK drive: a fixed-length low pulse, never stretched by later events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cec_send <= 1'b0;
      cec_out  <= 1'b1;
      ack_t    <= '0;
    end else if (do_ack) begin
      cec_send <= 1'b1;
      cec_out  <= 1'b0;
      ack_t    <= ACK_CYCLES - 17'd1;
    end else if (cec_send) begin
      if (ack_t == 17'd0) begin
        cec_send <= 1'b0;
        cec_out  <= 1'b1;
      end else begin
        ack_t <= ack_t - 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_cec_receiver.sv
// tb_cec_receiver
// Directed-stimulus bench for cec_receiver. An initiator model drives the
// open-drain line (wired-AND with the DUT's own drive). A symbol-level model
// predicts decoded blocks, frame errors and ACK-drive windows from the
// protocol timing rules; a monitor compares the DUT against it every cycle.
module tb_cec_receiver;

  localparam int START_MIN = 94_500;
  localparam int START_MAX = 105_300;
  localparam int ONE_MIN   = 10_800;
  localparam int ONE_MAX   = 21_600;
  localparam int ZERO_MIN  = 35_100;
  localparam int ZERO_MAX  = 45_900;
  localparam int SPER_MIN  = 116_100;
  localparam int SPER_MAX  = 126_900;
  localparam int BPER_MIN  = 55_350;
  localparam int HIGH_TO   = 74_250;
  localparam int ACK_LEN   = 40_500;
  localparam int DRV_LAT   = 3;

  localparam int ONE_L   = 16_200;
  localparam int ZERO_L  = 40_500;
  localparam int BIT_P   = 56_000;
  localparam int START_L = 99_900;
  localparam int START_P = 121_500;
  localparam int QUIET   = 80_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] logical_addr;
  logic       init_low;
  logic       cec_in;
  logic       cec_send, cec_out;
  logic [7:0] rx_data;
  logic       rx_eom, rx_header, rx_acked, rx_valid, frame_error;

  cec_receiver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .logical_addr (logical_addr),
    .cec_in       (cec_in),
    .cec_send     (cec_send),
    .cec_out      (cec_out),
    .rx_data      (rx_data),
    .rx_eom       (rx_eom),
    .rx_header    (rx_header),
    .rx_acked     (rx_acked),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  // Open-drain line: low if either the initiator or the DUT pulls it down.
  assign cec_in = ~(init_low | (cec_send & ~cec_out));

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    logic       eom;
    logic       hdr;
    logic       acked;
  } ev_t;

  ev_t exp_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;
  int exp_lo        = 0;
  int exp_hi        = -1;
  int send_cycles   = 0;
  int valid_seen    = 0;
  int err_seen      = 0;
  logic [7:0] last_data  = '0;
  logic       last_hdr   = 1'b0;
  logic       last_acked = 1'b0;
  bit   mon_en    = 1'b0;
  bit   prev_send = 1'b0;
  bit   prev_exp  = 1'b0;

  // Protocol model state (symbol level).
  bit m_gap = 1'b0, m_active = 1'b0, m_hdr = 1'b0, m_last_eom = 1'b0;
  bit m_bits[$];
  int m_dest = 0, m_per = 0, m_high = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int class_of(input int w);
    if (w >= START_MIN && w <= START_MAX) return 3;
    if (w >= ONE_MIN && w <= ONE_MAX)     return 1;
    if (w >= ZERO_MIN && w <= ZERO_MAX)   return 2;
    return 0;
  endfunction

  function automatic void push_err();
    ev_t e;
    e        = '0;
    e.is_err = 1'b1;
    exp_q.push_back(e);
    m_gap    = 1'b0;
    m_active = 1'b0;
  endfunction

  function automatic void model_timeout();
    if (m_gap && m_high >= HIGH_TO) begin
      if (!(m_bits.size() == 0 && !m_hdr && m_last_eom)) push_err();
      m_gap    = 1'b0;
      m_active = 1'b0;
    end
  endfunction

  // Predict the outcome of one low pulse of width L inside a period P.
  // Returns 1 when the DUT is expected to drive the ACK slot.
  function automatic bit model_sym(input int L, input int P);
    bit   drv;
    bit   ok;
    int   le, c, d, byte_v;
    ev_t  e;
    drv = 1'b0;
    if (m_gap) begin
      if (m_hdr && m_bits.size() == 0) ok = (m_per >= SPER_MIN && m_per <= SPER_MAX);
      else                             ok = (m_per >= BPER_MIN);
      if (!ok) begin
        push_err();
        m_per = P;
        return 1'b0;
      end
      if (m_bits.size() == 9) begin
        if (m_hdr) d = m_bits[4] * 8 + m_bits[5] * 4 + m_bits[6] * 2 + int'(m_bits[7]);
        else       d = m_dest;
        drv = (d != 15) && (d == int'(logical_addr)) && (logical_addr != 4'hF);
      end
    end
    le = drv ? ((L > ACK_LEN + DRV_LAT) ? L : ACK_LEN + DRV_LAT) : L;
    c  = class_of(le);
    if (c == 3) begin
      m_active = 1'b1;
      m_hdr    = 1'b1;
      m_bits.delete();
      m_gap    = 1'b1;
    end else if (c != 0 && m_active) begin
      m_bits.push_back(c == 1);
      if (m_bits.size() == 10) begin
        byte_v = 0;
        for (int i = 0; i < 8; i++) byte_v = byte_v * 2 + int'(m_bits[i]);
        if (m_hdr) m_dest = byte_v % 16;
        e        = '0;
        e.data   = 8'(byte_v);
        e.eom    = m_bits[8];
        e.hdr    = m_hdr;
        e.acked  = (m_dest != 15) ? !m_bits[9] : m_bits[9];
        exp_q.push_back(e);
        m_last_eom = m_bits[8];
        m_hdr      = 1'b0;
        m_bits.delete();
      end
      m_gap = 1'b1;
    end else begin
      push_err();
    end
    m_per  = P;
    m_high = P - le;
    model_timeout();
    return drv;
  endfunction

  // Drive one low pulse of L cycles; the next fall comes P cycles after this one.
  task automatic applyStimulus(input int L, input int P);
    bit drv;
    drv = model_sym(L, P);
    @(posedge clk);
    #1;
    init_low = 1'b1;
    if (drv) begin
      exp_lo = cyc + DRV_LAT;
      exp_hi = cyc + DRV_LAT + ACK_LEN - 1;
    end
    repeat (L) @(posedge clk);
    #1;
    init_low = 1'b0;
    repeat (P - L - 1) @(posedge clk);
  endtask

  task automatic line_idle(input int H);
    m_high += H;
    m_per  += H;
    model_timeout();
    repeat (H) @(posedge clk);
  endtask

  task automatic send_bit(input bit v);
    applyStimulus(v ? ONE_L : ZERO_L, BIT_P);
  endtask

  task automatic send_start();
    applyStimulus(START_L, START_P);
  endtask

  task automatic send_block(input logic [7:0] b, input bit eom, input bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(eom);
    send_bit(ack);
  endtask

  // Monitor: ACK-drive window, pulse exclusivity and decoded events.
  always @(negedge clk) begin
    bit  e;
    ev_t x;
    if (mon_en) begin
      e = (cyc >= exp_lo) && (cyc <= exp_hi);
      if (cec_send) send_cycles++;
      if ((cec_send !== prev_send) || (e != prev_exp)) begin
        checkOutput("cec_send window", 32'(cec_send), 32'(e));
        if (cec_send) checkOutput("cec_out while driving", 32'(cec_out), 32'd0);
      end
      prev_send = cec_send;
      prev_exp  = e;
      if (rx_valid || frame_error) begin
        checkOutput("rx_valid/frame_error exclusive", 32'(rx_valid & frame_error), 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unpredicted event, pending count", 32'(exp_q.size()), 32'd1);
        end else begin
          x = exp_q.pop_front();
          if (x.is_err)
            checkOutput("frame_error event", 32'({rx_valid, frame_error}), 32'b01);
          else
            checkOutput("rx_valid {v,data,eom,hdr,acked}",
                        32'({rx_valid, rx_data, rx_eom, rx_header, rx_acked}),
                        32'({1'b1, x.data, x.eom, x.hdr, x.acked}));
        end
        if (rx_valid) begin
          valid_seen++;
          last_data  = rx_data;
          last_hdr   = rx_header;
          last_acked = rx_acked;
        end else begin
          err_seen++;
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    init_low     = 1'b0;
    logical_addr = 4'd4;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset cec_send", 32'(cec_send), 32'd0);
    checkOutput("reset cec_out", 32'(cec_out), 32'd1);
    checkOutput("reset rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset rx_eom", 32'(rx_eom), 32'd0);
    checkOutput("reset rx_header", 32'(rx_header), 32'd0);
    checkOutput("reset rx_acked", 32'(rx_acked), 32'd0);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset frame_error", 32'(frame_error), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] directed frame to address 4");
    send_start();
    send_block(8'h04, 1'b0, 1'b1);
    send_block(8'h36, 1'b1, 1'b1);
    line_idle(QUIET);
    checkOutput("directed: rx_valid count", 32'(valid_seen), 32'd2);
    checkOutput("directed: last data", 32'(last_data), 32'h36);
    checkOutput("directed: last acked", 32'(last_acked), 32'd1);
    checkOutput("directed: ACK drive cycles", 32'(send_cycles), 32'd81000);
    checkOutput("directed: frame errors", 32'(err_seen), 32'd0);

    $display("[TB] broadcast header");
    send_start();
    send_block(8'h4F, 1'b1, 1'b1);
    line_idle(QUIET);
    checkOutput("broadcast: no drive", 32'(send_cycles), 32'd81000);
    checkOutput("broadcast: acked", 32'(last_acked), 32'd1);

    $display("[TB] header to another address");
    send_start();
    send_block(8'h05, 1'b1, 1'b1);
    line_idle(QUIET);
    checkOutput("other addr: data", 32'(last_data), 32'h05);
    checkOutput("other addr: acked", 32'(last_acked), 32'd0);
    checkOutput("other addr: no drive", 32'(send_cycles), 32'd81000);

    $display("[TB] 1.0 ms data bit");
    send_start();
    send_bit(1'b1);
    send_bit(1'b0);
    applyStimulus(27_000, BIT_P);
    line_idle(QUIET);
    checkOutput("bad width: frame errors", 32'(err_seen), 32'd1);
    checkOutput("bad width: rx_valid count", 32'(valid_seen), 32'd4);

    $display("[TB] high timeout after bit 4, then fresh frame");
    send_start();
    repeat (4) send_bit(1'b1);
    line_idle(81_000);
    checkOutput("timeout: frame errors", 32'(err_seen), 32'd2);
    send_start();
    send_block(8'h21, 1'b1, 1'b1);
    line_idle(QUIET);
    checkOutput("after timeout: data", 32'(last_data), 32'h21);
    checkOutput("after timeout: rx_valid count", 32'(valid_seen), 32'd5);

    $display("[TB] restart mid-block");
    send_start();
    repeat (3) send_bit(1'b0);
    send_start();
    send_block(8'h10, 1'b1, 1'b1);
    line_idle(QUIET);
    checkOutput("restart: rx_valid count", 32'(valid_seen), 32'd6);
    checkOutput("restart: header flag", 32'(last_hdr), 32'd1);
    checkOutput("restart: frame errors", 32'(err_seen), 32'd2);

    $display("[TB] inclusive class limits and saturation");
    applyStimulus(START_MIN, SPER_MIN);
    applyStimulus(ONE_MIN, BIT_P);
    applyStimulus(ZERO_MIN, BIT_P);
    applyStimulus(ONE_MAX, BIT_P);
    applyStimulus(ZERO_MAX, BIT_P);
    applyStimulus(ZERO_MIN, BPER_MIN);
    applyStimulus(ONE_MIN, BIT_P);
    applyStimulus(ZERO_MAX, BIT_P);
    applyStimulus(ONE_MAX, BIT_P);
    applyStimulus(ONE_MIN, BIT_P);
    applyStimulus(ONE_L, BIT_P);
    line_idle(QUIET);
    checkOutput("limits: data", 32'(last_data), 32'hA5);
    checkOutput("limits: frame errors", 32'(err_seen), 32'd2);
    applyStimulus(START_MAX, SPER_MAX);
    applyStimulus(ONE_MAX + 1, BIT_P);
    line_idle(QUIET);
    checkOutput("just over one limit: frame errors", 32'(err_seen), 32'd3);
    applyStimulus(135_000, 136_000);
    line_idle(1000);
    checkOutput("saturated low: frame errors", 32'(err_seen), 32'd4);
    checkOutput("total rx_valid count", 32'(valid_seen), 32'd7);

    checkOutput("unconsumed expected events", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/cec_receiver.md
# cec_receiver

Bit-level HDMI-CEC receiver for the 27 MHz video clock domain. It samples the open-drain CEC line, recognises start bits and decodes each 10-bit block (8 data bits, EOM, ACK). It drives the ACK bit low for header and data blocks addressed to its own logical address. It is the receive-side counterpart to the CEC transmitter: both share the `cec_in`/`cec_send`/`cec_out` pad interface, and the line arbiter ORs the two drive requests together.

## Interface
- CLK_HZ, 27_000_000: clock frequency. All timing constants below are given for this value and are fixed localparams in the block.
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous reset, active-low
- logical_addr  in  4  own CEC logical address; 4'hF disables directed ACK
- cec_in  in  1  raw CEC line level (asynchronous)
- cec_send  out  1  1 = the block is driving `cec_out` onto the line
- cec_out  out  1  level driven while `cec_send`=1 (always 0 when driving)
- rx_data  out  8  last received data byte, MSB first on the wire
- rx_eom  out  1  EOM bit of the last block
- rx_header  out  1  last block was the first block after a start bit
- rx_acked  out  1  ACK outcome of the last block (see ACK rules)
- rx_valid  out  1  one-cycle pulse; the rx_* fields are updated on the same cycle
- frame_error  out  1  one-cycle pulse on a timing violation; the frame is abandoned

## Operation
- `cec_in` passes through a 2-flop synchroniser. Falling and rising edges are detected on the synchronised level.
- A 17-bit up-counter `low_t` restarts at each falling edge and saturates at 131_071. A 17-bit counter `per_t` measures falling-edge-to-falling-edge time and also saturates.
- Low-width classes are evaluated at each rising edge:
  - start: 94_500..105_300 (3.5–3.9 ms)
  - one: 10_800..21_600 (0.4–0.8 ms)
  - zero: 35_100..45_900 (1.3–1.7 ms)
  - anything else is invalid.
- State machine:
  - IDLE: wait for a falling edge, then go to LOW.
  - LOW: on a rising edge, classify the low width.
    - start → go to GAP with bit_cnt=0 and hdr=1. This applies from any state except while the block is driving ACK, and restarts the frame.
    - one/zero with a frame active → shift the bit into `sr[9:0]`, increment bit_cnt, go to GAP.
    - invalid, or one/zero with no frame active → `frame_error`, go to IDLE.
  - GAP: on a falling edge, check the period.
    - After a start bit the period must be 116_100..126_900. After a data bit it must be ≥55_350.
    - Violation → `frame_error`, go to IDLE.
    - Otherwise go to LOW. If bit_cnt==9 (ACK slot), evaluate the ACK drive.
    - If the high time reaches 74_250 (2.75 ms) with no falling edge: go to IDLE with no error when bit_cnt==10 and EOM=1. In every other case raise `frame_error` and go to IDLE.
- Block completion at the rising edge ending bit 10:
  - rx_data=sr[9:2], rx_eom=sr[1], rx_header=hdr.
  - rx_acked: for directed frames (dest≠F), 1 when the ACK bit reads 0. For broadcast frames (dest==F), 1 when the ACK bit reads 1.
  - Pulse rx_valid. Clear hdr and bit_cnt.
  - The next block's bits then follow in GAP/LOW.
- Destination: on the header block, dest=rx_data[3:0]; it is held for the whole frame.
- ACK drive:
  - Condition: ACK slot, frame directed (dest≠F), dest==logical_addr, logical_addr≠F. For the header block, dest is taken from sr bits captured so far.
  - Action: set cec_send=1 and cec_out=0 for exactly 40_500 cycles (1.5 ms), then cec_send=0.
  - The block never drives broadcast ACKs; it does not reject broadcasts.
- An EOM=0 block that is not acknowledged still continues; ending the frame is the initiator's job.

## Timing
- Reset values: cec_send=0, cec_out=1, rx_data=0, rx_eom=0, rx_header=0, rx_acked=0, rx_valid=0, frame_error=0, state=IDLE, all counters 0.
- Line-to-edge latency is 3 cycles: 2 synchroniser cycles plus the edge register.
- The ACK drive starts 3 cycles after the line's falling edge. It ends 40_500 cycles later and is not extended.
- rx_valid and frame_error are mutually exclusive single-cycle pulses, registered.
- Boundary rules:
  - A rising edge at exactly a class limit is inside the class; limits are inclusive.
  - Counter saturation with the line held low → no class matches; `frame_error` fires on the eventual rising edge.
  - A start bit arriving mid-frame discards the partial block silently (no error) and restarts the frame.
  - Our own ACK drive is seen on `cec_in` and decoded as a zero bit.
- Reset asserted mid-ACK releases the line (cec_send=0) asynchronously.

## Test plan
- Directed frame, logical_addr=4: start, header 0x04 with EOM=0, data 0x36 with EOM=1. Required: ACK driven 40_500 cycles on both blocks; rx_valid twice with (0x04, eom0, hdr1, acked1) then (0x36, eom1, hdr0, acked1); IDLE 74_250 cycles after the last rise.
- Broadcast header 0x4F, EOM=1, line ACK left high → cec_send never asserted; rx_valid with rx_acked=1.
- Header 0x05 with logical_addr=4 → no drive, rx_acked=0.
- Data bit with a 1.0 ms low (27_000 cycles) → frame_error pulse, no rx_valid, state IDLE.
- Line held high for 3 ms after bit 4 → frame_error. A fresh start bit after that decodes normally.
- Start bit, 3 bits, then a second start bit, then a full block 0x10 with EOM=1 → a single rx_valid (0x10, hdr1) and no frame_error.
